sfu_row_collector: RTL
======================

Name: sfu_row_collector

Overview:
- Sits directly downstream of the SFU column array.
- Accepts per-column post-processed psums, which arrive skewed in time across columns. Buffers each column in a small lane FIFO.
- Emits one aligned, full-width output row per handshake, with an incrementing SRAM write address.
- A start/done run controller bounds each run to a programmed number of rows.

Parameters:
- col, 8, number of columns/lanes.
- psum_bw, 16, bits per lane sample.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of 2, at least 2.
- ADDR_W, 6, width of the output row address.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE or DONE.
- base_addr  input  ADDR_W  first row address of the run; captured at start.
- num_rows  input  ADDR_W+1  rows to write in this run; captured at start.
- valid_in  input  col  per-lane sample valid from the SFU stage.
- data_in  input  col*psum_bw  per-lane samples; lane i occupies bits [(i+1)*psum_bw-1 : i*psum_bw].
- row_valid  output  1  aligned row available.
- row_ready  input  1  consumer accepts the row.
- row_data  output  col*psum_bw  head entry of every lane, same lane ordering as data_in.
- row_addr  output  ADDR_W  write address for the current row.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- overflow  output  1  sticky; a sample was dropped.

Behaviour:
- Reset values: state IDLE; all FIFO pointers 0; row_addr 0; rows_left 0; busy, done, overflow, row_valid 0; row_data 0.
- State IDLE:
  - start=1 captures base_addr into row_addr and num_rows into rows_left.
  - It clears all lane FIFOs and overflow.
  - Next state is RUN, or DONE if num_rows==0.
- State RUN:
  - Lane push: valid_in[i]=1 writes data_in lane i into FIFO i.
  - Lane full with no pop that cycle: the sample is dropped and overflow is set.
  - Lane full with a pop in the same cycle: the push is accepted.
  - A write in cycle t is visible at the head in cycle t+1; there is no bypass.
  - row_valid = all col lanes non-empty.
  - row_valid is combinational from registered FIFO state and must not depend on row_ready.
  - Pop: row_valid & row_ready pops every lane simultaneously, increments row_addr (wraps modulo 2^ADDR_W) and decrements rows_left.
  - row_valid must not drop, and row_data/row_addr must stay stable, while row_ready=0.
  - Accepting the row with rows_left==1 moves the block to DONE on the next cycle.
  - start is ignored in RUN.
- State DONE:
  - done=1.
  - valid_in is ignored, with no overflow.
  - row_valid=0.
  - start=1 behaves as in IDLE.
- Outside RUN: row_valid=0, row_data=0, valid_in ignored.
- FIFO contents left over at DONE are discarded at the next start.
- row_data is gated to 0 whenever row_valid=0.
- reset asserted mid-run forces the reset values on the next edge. In-flight data is lost.
- Worst-case latency: last lane sample in cycle t gives row_valid in cycle t+1.

Optional Feature:
- Macro SFU_COLLECT_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt, 16 bits.
  - drop_cnt counts dropped samples summed over lanes, adding up to col per cycle.
  - It saturates at 0xFFFF.
  - It is cleared by reset and by an accepted start.
- Undefined: no drop_cnt port and no counter logic; overflow behaviour is unchanged.

Decomposition:
- Package sfu_collect_pkg:
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Drop counter width constant DROP_CNT_W = 16.
- Sub-module sfu_lane_fifo, instantiated col times in a generate loop:
  - Parameters psum_bw and FIFO_DEPTH.
  - Synchronous clear, push, pop, full, empty and head data.
  - Pointers are one bit wider than the index, for full/empty detection.

Test Plan:
Defaults throughout: col=8, psum_bw=16, FIFO_DEPTH=4, ADDR_W=6.
1. Skewed single row:
   - Stimulus: start with base_addr=5, num_rows=1; lane i valid in cycle i with data 0x100+i; row_ready=1.
   - Response: row_valid first in cycle 8; row_data lane i = 0x100+i; row_addr=5; done=1 next cycle.
2. Backpressure:
   - Stimulus: num_rows=3; all lanes push 3 rows back-to-back; row_ready=0 for 5 cycles.
   - Response: row_valid held and row_data stable while stalled; then rows at addresses base, base+1, base+2; overflow=0.
3. Overflow:
   - Stimulus: row_ready=0; lane 0 pushes 5 samples while the other lanes push 4.
   - Response: overflow=1; the 5th lane-0 sample is absent from all 4 rows; drop_cnt=1 when SFU_COLLECT_DROP_CNT_EN is defined.
4. Full with simultaneous pop:
   - Stimulus: all lanes full; row_ready=1 and valid_in=0xFF in the same cycle.
   - Response: push accepted; no overflow.
5. Address wrap and zero rows:
   - Stimulus: base_addr=62, num_rows=3.
   - Response: row addresses 62, 63, 0.
   - Stimulus: start with num_rows=0.
   - Response: DONE next cycle; row_valid never asserts.
6. Reset mid-run:
   - Stimulus: reset asserted while 2 rows are buffered.
   - Response: next cycle all outputs 0 and state IDLE; a following start runs cleanly with no stale rows.

Source files
------------

// File: rtl/sfu_collect_pkg.sv
// Shared definitions for the SFU row collector.
//   sfu_state_e : run controller state (IDLE, RUN, DONE), 2 bits.
//   DROP_CNT_W  : width of the optional dropped-sample counter.
package sfu_collect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sfu_state_e;

    localparam int unsigned DROP_CNT_W = 16;

endpackage

// File: rtl/sfu_lane_fifo.sv
// Single-lane FIFO used by the SFU row collector.
// Ports:
//   clk_i    : clock, rising edge
//   clear_i  : synchronous clear of both pointers
//   push_i   : write data_i (ignored when full unless pop_i is also high)
//   pop_i    : drop the head entry (ignored when empty)
//   data_i   : sample to write
//   full_o   : FIFO holds FIFO_DEPTH entries
//   empty_o  : FIFO holds no entries
//   head_o   : oldest entry; only meaningful when empty_o is low
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sfu_lane_fifo
    import sfu_collect_pkg::*;
#(
    parameter int unsigned psum_bw    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [psum_bw-1:0] data_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [psum_bw-1:0] head_o
);

    localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
    localparam logic [IdxW:0] PtrOne = (IdxW + 1)'(1);

    logic [IdxW:0]        wr_ptr_q, rd_ptr_q;
    logic [psum_bw-1:0]   mem_q [FIFO_DEPTH];
    logic                 do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

    // A push into a full FIFO is legal only when the head leaves in the same
    // cycle; the write then lands in the slot being vacated.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign head_o = mem_q[rd_ptr_q[IdxW-1:0]];

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // Storage needs no reset: head is only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sfu_row_collector.sv
// SFU row collector: realigns skewed per-column psums into full-width rows.
// Each column feeds its own lane FIFO; a row is offered when every lane has
// an entry, and each accepted row gets the next SRAM write address. A
// start/done controller bounds each run to num_rows rows.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start                 : begin a run (honoured in IDLE or DONE only)
//   base_addr, num_rows   : run parameters captured at start
//   valid_in, data_in     : per-lane samples, lane i at [(i+1)*psum_bw-1 : i*psum_bw]
//   row_valid, row_ready  : output row handshake
//   row_data, row_addr    : aligned row (zero when not valid) and its address
//   busy, done            : high in RUN / DONE
//   overflow              : sticky, a sample hit a full lane and was dropped
//   drop_cnt              : only with SFU_COLLECT_DROP_CNT_EN; saturating count
//                           of dropped samples summed over all lanes
module sfu_row_collector
    import sfu_collect_pkg::*;
#(
    parameter int unsigned col        = 8,
    parameter int unsigned psum_bw    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        num_rows,
    input  logic [col-1:0]         valid_in,
    input  logic [col*psum_bw-1:0] data_in,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [col*psum_bw-1:0] row_data,
    output logic [ADDR_W-1:0]      row_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
`ifdef SFU_COLLECT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`endif
);

    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
    localparam logic [ADDR_W:0]   RowsOne = (ADDR_W + 1)'(1);

    sfu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic [ADDR_W:0]     rows_left_q, rows_left_d;
    logic                overflow_q, overflow_d;

    logic                in_run;
    logic                start_accept;
    logic                fifo_clear;
    logic                pop;
    logic [col-1:0]      lane_full, lane_empty, lane_push, lane_drop;
    logic [col*psum_bw-1:0] head_flat;

    assign in_run       = (state_q == RUN);
    assign start_accept = start && (state_q != RUN);
    // Leftover lane contents from a previous run are discarded at start.
    assign fifo_clear   = reset || start_accept;

    // Depends only on registered FIFO state, never on row_ready.
    assign row_valid = in_run && (&(~lane_empty));
    assign pop       = row_valid && row_ready;

    always_comb begin
        lane_push = '0;
        lane_drop = '0;
        for (int unsigned i = 0; i < col; i++) begin
            lane_push[i] = in_run && valid_in[i] && (!lane_full[i] || pop);
            lane_drop[i] = in_run && valid_in[i] && lane_full[i] && !pop;
        end
    end

    for (genvar i = 0; i < col; i++) begin : g_lane
        sfu_lane_fifo #(
            .psum_bw    (psum_bw),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .clear_i (fifo_clear),
            .push_i  (lane_push[i]),
            .pop_i   (pop),
            .data_i  (data_in[i*psum_bw +: psum_bw]),
            .full_o  (lane_full[i]),
            .empty_o (lane_empty[i]),
            .head_o  (head_flat[i*psum_bw +: psum_bw])
        );
    end

    assign row_data = row_valid ? head_flat : '0;
    assign row_addr = row_addr_q;
    assign busy     = in_run;
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;

    always_comb begin
        state_d     = state_q;
        row_addr_d  = row_addr_q;
        rows_left_d = rows_left_q;
        overflow_d  = overflow_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    row_addr_d  = base_addr;
                    rows_left_d = num_rows;
                    overflow_d  = 1'b0;
                    state_d     = (num_rows == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (|lane_drop) overflow_d = 1'b1;
                if (pop) begin
                    row_addr_d  = row_addr_q + AddrOne;
                    rows_left_d = rows_left_q - RowsOne;
                    if (rows_left_q == RowsOne) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            row_addr_q  <= '0;
            rows_left_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_addr_q  <= row_addr_d;
            rows_left_q <= rows_left_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef SFU_COLLECT_DROP_CNT_EN
    localparam logic [DROP_CNT_W:0] DropOne = (DROP_CNT_W + 1)'(1);

    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DROP_CNT_W:0]   drop_sum;

    // One extra bit catches the carry so the count can saturate at all-ones.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int unsigned i = 0; i < col; i++) begin
            if (lane_drop[i]) drop_sum = drop_sum + DropOne;
        end
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        if (start_accept) drop_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
